// File: rtl/fifo_reader.sv
// fifo_reader: drains an upstream FIFO into a 2-entry in-order output buffer
// with ready/valid delivery, an IDLE/ACTIVE/FLUSH controller and a transfer counter.
module fifo_reader #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rd_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [15:0]      word_count,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
   state_t state, state_nx;
   logic [1:0] occ, occ_nx, widx;
   logic pend, pop;
   logic [WIDTH-1:0] b0, b1;
   assign out_valid = occ != 2'd0;
   assign out_data = b0;
   assign pop = out_valid & out_ready;
   assign busy = state != IDLE;
   assign widx = occ - {1'b0, pop};
   assign occ_nx = widx + {1'b0, pend};
   // occ_nx already counts this cycle's pop and capture, so a slot freed now is refilled at once
   assign fifo_rd_en = !rst & enable & !fifo_empty & (state == ACTIVE) & (occ_nx < 2'd2);
   always_comb
      state_nx = enable ? ACTIVE
               : state == ACTIVE ? ((occ != 2'd0 || pend) ? FLUSH : IDLE)
               : state == FLUSH ? ((occ_nx != 2'd0) ? FLUSH : IDLE)
               : IDLE;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         occ <= 2'd0;
         pend <= 1'b0;
         b0 <= '0;
         b1 <= '0;
         word_count <= '0;
      end else begin
         state <= state_nx;
         occ <= occ_nx;
         pend <= fifo_rd_en;
         b0 <= (pend && widx == 2'd0) ? fifo_rd_data : pop ? b1 : b0;
         b1 <= (pend && widx == 2'd1) ? fifo_rd_data : b1;
         word_count <= word_count + 16'(pop);
      end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed and random stimulus against a queue-based FIFO and
// delivery scoreboard (every read word must appear in order, two cycles later at the earliest).
module tb_fifo_reader;
   localparam int WIDTH = 8;
   typedef struct {logic [WIDTH-1:0] d; int t;} ent_t;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, fifo_empty = 1'b1, out_ready = 1'b0;
   logic fifo_rd_en, out_valid, busy, ev;
   logic [WIDTH-1:0] fifo_rd_data = '0, out_data, nxt = '0;
   logic [15:0] word_count, wc_exp = '0;
   logic [WIDTH-1:0] q[$];
   ent_t exp_q[$];
   int cyc = 0, vectors = 0, errors = 0;

   fifo_reader #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .word_count(word_count), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      enable = 1'b0;
      out_ready = 1'b0;
      q.delete();
      step(2);
      rst = 1'b0;
   endtask

   task automatic drain(input string tag, input int bound);
      int i;
      enable = 1'b1;
      out_ready = 1'b1;
      for (i = 0; i < bound && !(q.size() == 0 && exp_q.size() == 0 && !out_valid); i++) step(1);
      chk(tag, 32'(i < bound), 32'd1);
   endtask

   // upstream FIFO: read data and empty flag both follow the clock edge
   initial forever begin
      @(posedge clk);
      fifo_rd_data <= nxt;
      fifo_empty <= (q.size() == 0);
   end

   // scoreboard sampled mid-cycle
   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
         chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
         exp_q.delete();
         wc_exp = '0;
      end else begin
         ev = (exp_q.size() > 0) ? (exp_q[0].t <= cyc) : 1'b0;
         chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
         chk("out_valid", 32'(out_valid), 32'(ev));
         chk("word_count", 32'(word_count), 32'(wc_exp));
         if (ev && out_ready) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0].d));
            void'(exp_q.pop_front());
            wc_exp++;
         end
         if (fifo_rd_en && q.size() > 0) begin
            nxt = q.pop_front();
            exp_q.push_back('{nxt, cyc + 2});
         end
         chk("in_flight_limit", 32'(exp_q.size() <= 2), 32'd1);
      end
   end

   initial begin
      int k, rd_n;
      logic [WIDTH-1:0] held;
      step(2);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      // single word
      q.push_back(8'hA5);
      enable = 1'b1;
      out_ready = 1'b1;
      step(1);
      chk("single_rd", 32'(fifo_rd_en), 32'd1);
      step(1);
      chk("single_rd_once", 32'(fifo_rd_en), 32'd0);
      chk("single_latency", 32'(out_valid), 32'd0);
      step(1);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'hA5);
      chk("single_no_rd", 32'(fifo_rd_en), 32'd0);
      step(1);
      chk("single_done", 32'(out_valid), 32'd0);
      chk("single_count", 32'(word_count), 32'd1);
      chk("single_busy", 32'(busy), 32'd1);
      enable = 1'b0;
      step(1);
      chk("single_idle", 32'(busy), 32'd0);
      // streaming
      do_reset();
      chk("reset_clears_data", 32'(out_data), 32'd0);
      for (int i = 1; i <= 8; i++) q.push_back(8'(i));
      enable = 1'b1;
      out_ready = 1'b1;
      step(1);
      for (k = 0; k < 6 && !out_valid; k++) step(1);
      chk("stream_start", 32'(k < 6), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_data", 32'(out_data), 32'(i));
         step(1);
      end
      chk("stream_count", 32'(word_count), 32'd8);
      chk("stream_end", 32'(out_valid), 32'd0);
      // backpressure
      do_reset();
      for (int i = 0; i < 5; i++) q.push_back(8'(8'h30 + i));
      enable = 1'b1;
      rd_n = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         rd_n += int'(fifo_rd_en);
         if (i == 2) held = out_data;
         if (i > 2) chk("bp_stable", 32'(out_data), 32'(held));
      end
      chk("bp_reads", 32'(rd_n), 32'd2);
      chk("bp_left", 32'(q.size()), 32'd3);
      chk("bp_head", 32'(out_data), 32'h30);
      drain("bp_drain", 30);
      chk("bp_count", 32'(word_count), 32'd5);
      // flush
      do_reset();
      for (int i = 0; i < 4; i++) q.push_back(8'(8'h50 + i));
      enable = 1'b1;
      step(3);
      chk("flush_buffered", 32'(out_valid), 32'd1);
      enable = 1'b0;
      out_ready = 1'b1;
      step(1);
      chk("flush_busy", 32'(busy), 32'd1);
      chk("flush_no_rd", 32'(fifo_rd_en), 32'd0);
      chk("flush_second", 32'(out_data), 32'h51);
      step(1);
      chk("flush_idle", 32'(busy), 32'd0);
      chk("flush_empty", 32'(out_valid), 32'd0);
      chk("flush_count", 32'(word_count), 32'd2);
      chk("flush_fifo_left", 32'(q.size()), 32'd2);
      // reset mid-stream
      do_reset();
      for (int i = 0; i < 10; i++) q.push_back(8'(8'h10 + i));
      enable = 1'b1;
      out_ready = 1'b1;
      step(5);
      chk("mid_streaming", 32'(out_valid & fifo_rd_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      step(1);
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_count", 32'(word_count), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      enable = 1'b0;
      step(3);
      chk("mid_quiet", 32'(out_valid | fifo_rd_en), 32'd0);
      enable = 1'b1;
      for (k = 0; k < 6 && !out_valid; k++) step(1);
      chk("mid_first", 32'(out_data), 32'h14);
      drain("mid_drain", 30);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) != 0 && q.size() < 6) q.push_back(8'($urandom));
         enable = $urandom_range(7) != 0;
         out_ready = 1'($urandom_range(1));
         step(1);
      end
      drain("rand_drain", 60);
      // counter wrap
      do_reset();
      for (int i = 0; i < 65540; i++) q.push_back(8'($urandom));
      enable = 1'b1;
      out_ready = 1'b1;
      for (k = 0; k < 66000 && word_count !== 16'hFFFF; k++) step(1);
      chk("wrap_reach", 32'(k < 66000), 32'd1);
      step(1);
      chk("wrap", 32'(word_count), 32'd0);
      do_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
